// File: rtl/queue_ctrl_pkg.sv
// Shared definitions for the queue access controller.
// Holds the FSM state encoding, the requester index constants used to
// address the one-hot grant vector, and the default sizing parameters.
package queue_ctrl_pkg;

  // Default sizing: byte-wide queue of 1024 entries, count wide enough for 0..1024
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1024;
  localparam int CNT_W_DEF  = 11;

  // Two-state FSM, kept as plain constants so older tools can read it
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  // Requester positions in the eligible/grant vectors and round-robin order
  localparam int         NUM_REQ = 3;
  localparam logic [1:0] REQ_WR0 = 2'd0;
  localparam logic [1:0] REQ_WR1 = 2'd1;
  localparam logic [1:0] REQ_RD  = 2'd2;

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker.
// Ports:
//   eligible_i - one bit per requester (wr0, wr1, rd) that may be served now
//   ptr_i      - requester index with highest priority this round
//   grant_o    - one-hot winner, all zero when nothing is eligible
//   any_o      - at least one requester is eligible
module rr_arbiter3
  import queue_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               any_o
);

  assign any_o = |eligible_i;

  // Search starts at the pointer and wraps wr0 -> wr1 -> rd -> wr0.
  // The pointer never holds 3, so that value folds into the wr0-first order.
  always_comb begin
    grant_o = '0;
    case (ptr_i)
      REQ_WR1: begin
        if      (eligible_i[REQ_WR1]) grant_o[REQ_WR1] = 1'b1;
        else if (eligible_i[REQ_RD])  grant_o[REQ_RD]  = 1'b1;
        else if (eligible_i[REQ_WR0]) grant_o[REQ_WR0] = 1'b1;
      end
      REQ_RD: begin
        if      (eligible_i[REQ_RD])  grant_o[REQ_RD]  = 1'b1;
        else if (eligible_i[REQ_WR0]) grant_o[REQ_WR0] = 1'b1;
        else if (eligible_i[REQ_WR1]) grant_o[REQ_WR1] = 1'b1;
      end
      default: begin
        if      (eligible_i[REQ_WR0]) grant_o[REQ_WR0] = 1'b1;
        else if (eligible_i[REQ_WR1]) grant_o[REQ_WR1] = 1'b1;
        else if (eligible_i[REQ_RD])  grant_o[REQ_RD]  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/queue_access_ctrl.sv
// Sequencing controller sharing one single-port byte queue between two
// writers and one reader, with round-robin arbitration and full/empty gating.
// Ports:
//   Clk_i, Rst_i            - clock (rising edge), async active-low reset
//   wrN_req_i/_data_i/_ack_o - writer N push handshake (N = 0, 1)
//   rd_req_i/rd_ack_o       - reader pop handshake
//   rd_data_o/rd_valid_o    - popped byte, valid one cycle after rd_ack_o
//   q_en_o/q_rw_o/q_data_o  - queue enable, op select (1=push) and write data
//   q_data_i/q_full_i/q_empty_i - queue read data and status flags
//   count_o                 - occupancy tracked by the controller
//   busy_o                  - high while an op is being issued
module queue_access_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              wr0_req_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  output logic              wr0_ack_o,
  input  logic              wr1_req_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  output logic              wr1_ack_o,
  input  logic              rd_req_i,
  output logic              rd_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              q_en_o,
  output logic              q_rw_o,
  output logic [DATA_W-1:0] q_data_o,
  input  logic [DATA_W-1:0] q_data_i,
  input  logic              q_full_i,
  input  logic              q_empty_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              busy_o
);

  logic               state_q,    state_d;
  logic [1:0]         ptr_q,      ptr_d;
  logic [NUM_REQ-1:0] winner_q,   winner_d;
  logic               q_rw_q,     q_rw_d;
  logic [DATA_W-1:0]  q_data_q,   q_data_d;
  logic [DATA_W-1:0]  rd_data_q,  rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   count_q,    count_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               issuing;

  // Flags are only trusted in IDLE, where the previous op has fully settled
  assign eligible[REQ_WR0] = wr0_req_i & ~q_full_i;
  assign eligible[REQ_WR1] = wr1_req_i & ~q_full_i;
  assign eligible[REQ_RD]  = rd_req_i  & ~q_empty_i;

  rr_arbiter3 u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .any_o      (grant_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    q_rw_d     = q_rw_q;
    q_data_d   = q_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d  = ST_ISSUE;
          winner_d = grant;
          q_rw_d   = ~grant[REQ_RD];
          if (grant[REQ_WR0])      q_data_d = wr0_data_i;
          else if (grant[REQ_WR1]) q_data_d = wr1_data_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        // Next round starts just after the requester served now
        if (winner_q[REQ_WR0])      ptr_d = REQ_WR1;
        else if (winner_q[REQ_WR1]) ptr_d = REQ_RD;
        else                        ptr_d = REQ_WR0;
        if (q_rw_q) begin
          if (count_q < CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
        end else begin
          rd_data_d  = q_data_i;
          rd_valid_d = 1'b1;
          if (count_q != '0) count_d = count_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= REQ_WR0;
      winner_q   <= '0;
      q_rw_q     <= 1'b0;
      q_data_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      q_rw_q     <= q_rw_d;
      q_data_q   <= q_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
    end
  end

  // Acks are decoded from state so an async reset drops them at once
  assign issuing    = (state_q == ST_ISSUE);
  assign q_en_o     = issuing;
  assign busy_o     = issuing;
  assign wr0_ack_o  = issuing & winner_q[REQ_WR0];
  assign wr1_ack_o  = issuing & winner_q[REQ_WR1];
  assign rd_ack_o   = issuing & winner_q[REQ_RD];
  assign q_rw_o     = q_rw_q;
  assign q_data_o   = q_data_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;

endmodule
